// File: rtl/rnn_mem_responder.sv
// Memory and stimulus responder facing the RNN core: weight/bias/config banks,
// hidden-state capture memory, x-vector stream and the start handshake.
module rnn_mem_responder #(
   parameter int unsigned DW    = 20,
   parameter int unsigned AW    = 17,
   parameter int unsigned XW    = 32,
   parameter int unsigned T_MAX = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_we,
   input  logic [2:0]    host_sel,
   input  logic [AW-1:0] host_addr,
   input  logic [XW-1:0] host_wdata,
   input  logic          host_start,
   input  logic [AW-1:0] host_rd_addr,
   output logic [DW-1:0] host_rd_data,
   output logic          done,
   output logic          oob_err,
   output logic          ready,
   input  logic          busy,
   input  logic          i_en,
   output logic [XW-1:0] idata,
   input  logic          mce,
   input  logic [2:0]    msel,
   input  logic [AW-1:0] maddr,
   input  logic [DW-1:0] mdata_w,
   output logic [DW-1:0] mdata_r
);

   localparam int unsigned WIH_AW    = 11;
   localparam int unsigned WHH_AW    = 12;
   localparam int unsigned B_AW      = 6;
   localparam int unsigned OUT_DEPTH = T_MAX * 64;
   localparam int unsigned OUT_AW    = $clog2(OUT_DEPTH);
   localparam int unsigned XPW       = $clog2(T_MAX);
   localparam logic [AW-1:0]  OUT_LIMIT = AW'(OUT_DEPTH);
   localparam logic [XPW-1:0] X_LAST    = XPW'(T_MAX - 1);

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

   state_e         state_q, state_d;
   logic           ready_q, ready_d;
   logic           done_q, done_d;
   logic           oob_err_q, oob_err_d;
   logic [DW-1:0]  mdata_r_q, mdata_r_d;
   logic [DW-1:0]  host_rd_data_q, host_rd_data_d;
   logic [XW-1:0]  idata_q, idata_d;
   logic [XPW-1:0] x_ptr_q, x_ptr_d;
   logic [DW-1:0]  seq_len_q, seq_len_d;

   logic [DW-1:0] w_ih_mem [0:(1<<WIH_AW)-1];
   logic [DW-1:0] b_ih_mem [0:(1<<B_AW)-1];
   logic [DW-1:0] w_hh_mem [0:(1<<WHH_AW)-1];
   logic [DW-1:0] b_hh_mem [0:(1<<B_AW)-1];
   logic [DW-1:0] out_mem  [0:OUT_DEPTH-1];
   logic [XW-1:0] x_mem    [0:T_MAX-1];

   logic host_ok, wih_we, bih_we, whh_we, bhh_we, cfg_we, x_we;
   logic core_wr, out_in_range, out_we;

   // Host writes are only honoured while the core is not using the banks
   always_comb begin
      host_ok      = host_we && ((state_q == IDLE) || (state_q == DONE));
      wih_we       = host_ok && (host_sel == 3'b000);
      bih_we       = host_ok && (host_sel == 3'b001);
      whh_we       = host_ok && (host_sel == 3'b010);
      bhh_we       = host_ok && (host_sel == 3'b011);
      cfg_we       = host_ok && (host_sel == 3'b100) && (host_addr == '0);
      x_we         = host_ok && (host_sel == 3'b110);
      core_wr      = mce && (msel == 3'b101);
      out_in_range = (maddr < OUT_LIMIT);
      out_we       = core_wr && out_in_range;
      seq_len_d    = cfg_we ? host_wdata[DW-1:0] : seq_len_q;
   end

   // Storage arrays and seq_len survive reset
   always_ff @(posedge clk) begin
      if (wih_we) w_ih_mem[host_addr[WIH_AW-1:0]] <= host_wdata[DW-1:0];
      if (bih_we) b_ih_mem[host_addr[B_AW-1:0]]   <= host_wdata[DW-1:0];
      if (whh_we) w_hh_mem[host_addr[WHH_AW-1:0]] <= host_wdata[DW-1:0];
      if (bhh_we) b_hh_mem[host_addr[B_AW-1:0]]   <= host_wdata[DW-1:0];
      if (x_we)   x_mem[host_addr[XPW-1:0]]       <= host_wdata;
      if (out_we) out_mem[maddr[OUT_AW-1:0]]      <= mdata_w;
      seq_len_q <= seq_len_d;
   end

   // Core read mux, capture-write error flag and host readback
   always_comb begin
      mdata_r_d = mdata_r_q;
      if (mce) begin
         case (msel)
            3'b000:  mdata_r_d = w_ih_mem[maddr[WIH_AW-1:0]];
            3'b001:  mdata_r_d = b_ih_mem[maddr[B_AW-1:0]];
            3'b010:  mdata_r_d = w_hh_mem[maddr[WHH_AW-1:0]];
            3'b011:  mdata_r_d = b_hh_mem[maddr[B_AW-1:0]];
            3'b100:  mdata_r_d = (maddr == '0) ? seq_len_q : '0;
            3'b101:  mdata_r_d = mdata_r_q;
            default: mdata_r_d = '0;
         endcase
      end
      oob_err_d      = oob_err_q | (core_wr & ~out_in_range);
      host_rd_data_d = (host_rd_addr < OUT_LIMIT) ? out_mem[host_rd_addr[OUT_AW-1:0]] : '0;
   end

   // Start handshake and x-stream pointer
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      done_d  = done_q;
      x_ptr_d = x_ptr_q;
      idata_d = x_mem[x_ptr_q];
      case (state_q)
         IDLE, DONE: begin
            if (host_start) begin
               state_d = ARM;
               ready_d = 1'b1;
               done_d  = 1'b0;
               x_ptr_d = '0;
               idata_d = x_mem[0];
            end
         end
         ARM: begin
            if (busy) begin
               state_d = RUN;
               ready_d = 1'b0;
            end
         end
         RUN: begin
            if (i_en) x_ptr_d = (x_ptr_q == X_LAST) ? '0 : x_ptr_q + XPW'(1);
            if (!busy) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         ready_q        <= 1'b0;
         done_q         <= 1'b0;
         oob_err_q      <= 1'b0;
         mdata_r_q      <= '0;
         host_rd_data_q <= '0;
         idata_q        <= '0;
         x_ptr_q        <= '0;
      end else begin
         state_q        <= state_d;
         ready_q        <= ready_d;
         done_q         <= done_d;
         oob_err_q      <= oob_err_d;
         mdata_r_q      <= mdata_r_d;
         host_rd_data_q <= host_rd_data_d;
         idata_q        <= idata_d;
         x_ptr_q        <= x_ptr_d;
      end
   end

   assign ready        = ready_q;
   assign done         = done_q;
   assign oob_err      = oob_err_q;
   assign mdata_r      = mdata_r_q;
   assign host_rd_data = host_rd_data_q;
   assign idata        = idata_q;

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed/randomized bench for rnn_mem_responder with a bank-level reference model.
module tb_rnn_mem_responder;

   localparam int DW = 20;
   localparam int AW = 17;
   localparam int XW = 32;
   localparam int T_MAX = 16;
   localparam int OUT_DEPTH = T_MAX * 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          host_we;
   logic [2:0]    host_sel;
   logic [AW-1:0] host_addr;
   logic [XW-1:0] host_wdata;
   logic          host_start;
   logic [AW-1:0] host_rd_addr;
   logic [DW-1:0] host_rd_data;
   logic          done, oob_err, ready;
   logic          busy, i_en;
   logic [XW-1:0] idata;
   logic          mce;
   logic [2:0]    msel;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mdata_w;
   logic [DW-1:0] mdata_r;

   rnn_mem_responder dut (
      .clk(clk), .reset(reset),
      .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_start(host_start), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
      .done(done), .oob_err(oob_err), .ready(ready), .busy(busy), .i_en(i_en), .idata(idata),
      .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r)
   );

   always #5 clk = ~clk;

   // Reference model: banks as plain arrays indexed by address modulo bank size
   logic [DW-1:0] wih_m [2048];
   logic [DW-1:0] bih_m [64];
   logic [DW-1:0] whh_m [4096];
   logic [DW-1:0] bhh_m [64];
   logic [DW-1:0] out_m [OUT_DEPTH];
   logic [XW-1:0] x_m   [T_MAX];
   logic [DW-1:0] seq_m;
   string         phase;
   int            ptr;

   int errors = 0;
   int checks = 0;

   logic [2:0]  qsel [$];
   logic [16:0] qaddr [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [2:0] s, input logic [16:0] a);
      case (s)
         3'd0:    return 32'(wih_m[int'(a) % 2048]);
         3'd1:    return 32'(bih_m[int'(a) % 64]);
         3'd2:    return 32'(whh_m[int'(a) % 4096]);
         3'd3:    return 32'(bhh_m[int'(a) % 64]);
         3'd4:    return (a == 17'd0) ? 32'(seq_m) : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic host_wr(input logic [2:0] s, input logic [16:0] a, input logic [31:0] d);
      host_we = 1'b1; host_sel = s; host_addr = a; host_wdata = d;
      tick();
      host_we = 1'b0;
      if (phase == "idle" || phase == "done") begin
         case (s)
            3'd0: wih_m[int'(a) % 2048] = d[DW-1:0];
            3'd1: bih_m[int'(a) % 64]   = d[DW-1:0];
            3'd2: whh_m[int'(a) % 4096] = d[DW-1:0];
            3'd3: bhh_m[int'(a) % 64]   = d[DW-1:0];
            3'd4: if (a == 17'd0) seq_m = d[DW-1:0];
            3'd6: x_m[int'(a) % T_MAX]  = d;
            default: ;
         endcase
      end
   endtask

   task automatic core_rd(input string tag, input logic [2:0] s, input logic [16:0] a);
      mce = 1'b1; msel = s; maddr = a;
      tick();
      mce = 1'b0;
      chk(tag, 32'(mdata_r), exp_rd(s, a));
   endtask

   task automatic core_wr(input logic [16:0] a, input logic [DW-1:0] d);
      mce = 1'b1; msel = 3'b101; maddr = a; mdata_w = d;
      tick();
      mce = 1'b0;
      if (int'(a) < OUT_DEPTH) out_m[int'(a)] = d;
   endtask

   task automatic rb(input string tag, input logic [16:0] a);
      host_rd_addr = a;
      tick();
      chk(tag, 32'(host_rd_data), (int'(a) < OUT_DEPTH) ? 32'(out_m[int'(a)]) : 32'd0);
   endtask

   // idata after an edge shows the head as it stood before that edge
   task automatic pop_cycles(input int n, input bit force_pop);
      logic [XW-1:0] exp;
      for (int k = 0; k < n; k++) begin
         i_en = force_pop ? 1'b1 : 1'($urandom_range(0, 1));
         exp = x_m[ptr];
         tick();
         if (i_en) ptr = (ptr + 1) % T_MAX;
         chk("idata_run", idata, exp);
      end
      i_en = 1'b0;
   endtask

   initial begin
      logic [16:0] a;
      logic [DW-1:0] d, v1, v2;
      reset = 1'b1; host_we = 1'b0; host_sel = '0; host_addr = '0; host_wdata = '0;
      host_start = 1'b0; host_rd_addr = '0; busy = 1'b0; i_en = 1'b0;
      mce = 1'b0; msel = '0; maddr = '0; mdata_w = '0;
      phase = "idle"; ptr = 0; seq_m = '0;

      tick(); tick();
      reset = 1'b0;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mdata_r", 32'(mdata_r), 32'd0);
      chk("rst_idata", idata, 32'd0);
      chk("rst_oob", 32'(oob_err), 32'd0);

      // Bank preload and core reads
      host_wr(3'd2, 17'hABC, 32'h12345);
      core_rd("whh_abc", 3'd2, 17'hABC);
      maddr = 17'h1;
      tick();
      chk("mdata_hold_mce0", 32'(mdata_r), 32'h12345);
      for (int i = 0; i < 6; i++) begin
         for (int s = 0; s < 4; s++) begin
            a = 17'($urandom);
            if (s == 2 && a[11:0] == 12'hABC) a[0] = ~a[0];
            host_wr(3'(s), a, $urandom);
            qsel.push_back(3'(s));
            qaddr.push_back(a);
         end
      end
      foreach (qsel[i]) core_rd("bank_rd", qsel[i], qaddr[i]);
      foreach (qsel[i]) core_rd("bank_rd_alias", qsel[i], qaddr[i] ^ 17'h1F000);
      host_wr(3'd4, 17'd0, $urandom);
      host_wr(3'd4, 17'd3, $urandom);
      core_rd("cfg_seq_len", 3'd4, 17'd0);
      core_rd("cfg_other", 3'd4, 17'd7);
      core_rd("sel110_zero", 3'd6, 17'($urandom));
      core_rd("sel111_zero", 3'd7, 17'($urandom));

      // Output capture, readback, hazard and out-of-range handling
      core_rd("whh_abc_again", 3'd2, 17'hABC);
      core_wr({11'd2, 6'd5}, 20'hF0000);
      chk("mdata_hold_on_write", 32'(mdata_r), 32'h12345);
      rb("rb_133", 17'd133);
      for (int i = 0; i < 6; i++) begin
         a = 17'($urandom_range(0, OUT_DEPTH - 1));
         if (a == 17'd133 || a == 17'd200) a = 17'd300;
         core_wr(a, 20'($urandom));
         rb("rb_rand", a);
      end
      v1 = 20'($urandom); v2 = ~v1;
      core_wr(17'd200, v1);
      mce = 1'b1; msel = 3'b101; maddr = 17'd200; mdata_w = v2; host_rd_addr = 17'd200;
      tick();
      mce = 1'b0;
      chk("rb_same_cycle_old", 32'(host_rd_data), 32'(v1));
      out_m[200] = v2;
      rb("rb_after_write", 17'd200);
      chk("oob_before", 32'(oob_err), 32'd0);
      core_wr(17'd1024, 20'h00ABC);
      chk("oob_set", 32'(oob_err), 32'd1);
      rb("rb_oor", 17'd1024);
      core_wr(17'd5, 20'h00001);
      chk("oob_sticky", 32'(oob_err), 32'd1);

      // x FIFO load and run handshake
      for (int i = 0; i < T_MAX; i++) host_wr(3'd6, 17'(i), $urandom);
      host_start = 1'b1;
      tick();
      host_start = 1'b0; phase = "arm"; ptr = 0;
      chk("start_ready", 32'(ready), 32'd1);
      chk("start_idata", idata, x_m[0]);
      chk("start_done", 32'(done), 32'd0);
      i_en = 1'b1;
      tick();
      i_en = 1'b0;
      tick();
      chk("i_en_ignored_arm", idata, x_m[0]);
      host_wr(3'd2, 17'hABC, 32'h55555);
      host_start = 1'b1; busy = 1'b1;
      tick();
      host_start = 1'b0; phase = "run";
      chk("busy_wins_ready", 32'(ready), 32'd0);
      pop_cycles(1, 1'b1);
      pop_cycles(1, 1'b0);
      chk("idata_second", idata, x_m[1]);
      pop_cycles(40, 1'b0);
      host_start = 1'b1;
      tick();
      host_start = 1'b0;
      chk("start_ignored_run_ready", 32'(ready), 32'd0);
      chk("start_ignored_run_done", 32'(done), 32'd0);
      core_rd("arm_write_dropped", 3'd2, 17'hABC);
      repeat (56) tick();
      chk("run_not_done", 32'(done), 32'd0);
      busy = 1'b0;
      tick();
      phase = "done";
      chk("done_set", 32'(done), 32'd1);
      chk("done_ready", 32'(ready), 32'd0);
      d = 20'($urandom);
      host_wr(3'd4, 17'd0, 32'(d));
      core_rd("cfg_in_done", 3'd4, 17'd0);
      host_start = 1'b1;
      tick();
      host_start = 1'b0; phase = "arm"; ptr = 0;
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_ready", 32'(ready), 32'd1);
      chk("restart_idata", idata, x_m[0]);

      // Reset in the middle of a run
      busy = 1'b1;
      tick();
      phase = "run";
      pop_cycles(5, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0; busy = 1'b0; phase = "idle"; ptr = 0;
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_idata", idata, 32'd0);
      chk("mid_rst_oob", 32'(oob_err), 32'd0);
      tick();
      chk("mid_rst_ptr0", idata, x_m[0]);
      core_rd("mid_rst_whh", 3'd2, 17'hABC);
      rb("mid_rst_out", 17'd133);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
